frame_buffer_pp: RTL and testbench

Double-buffered (ping-pong) frame store between the camera capture logic and the VGA / processing readers. The writer fills the back bank while the VGA and processing ports read a stable front bank. Banks swap only at a VGA frame start, and only after a complete frame has been written, so no tearing can occur. Out-of-image read addresses return a parameterised fill colour, and illegal write addresses are flagged.

---
 rtl/frame_buffer_pp.sv | 127 ++++++++++++
 tb/tb_frame_buffer_pp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_pp.sv
// Ping-pong frame store: capture fills the back bank while VGA and processing
// read the front bank; banks swap only on a VGA frame start after a full frame.
module frame_buffer_pp #(
  parameter int            AW    = 15,
  parameter int            DW    = 12,
  parameter int            IMG_W = 160,
  parameter int            IMG_H = 120,
  parameter logic [DW-1:0] BLANK = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_frame_end,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          rd_frame_start,
  input  logic          proc_rd_en,
  input  logic [AW-1:0] proc_addr,
  output logic [DW-1:0] proc_data,
  output logic          proc_valid,
  output logic          wr_bank,
  output logic          frame_ready,
  output logic          frame_dropped,
  output logic          wr_oob
);

  // state    | meaning
  // ST_FILL  | back bank being filled, no complete frame waiting
  // ST_READY | complete frame in back bank, waiting for a VGA frame start

  localparam int              NPIX   = IMG_W * IMG_H;
  localparam int              PAW    = $clog2(2 * NPIX);
  localparam logic [AW:0]     NPIX_A = NPIX[AW:0];
  localparam logic [PAW-1:0]  NPIX_P = NPIX[PAW-1:0];

  typedef enum logic {ST_FILL, ST_READY} state_t;
  typedef enum logic [1:0] {SEL_ZERO, SEL_BLANK, SEL_MEM} sel_t;

  state_t         state, state_nxt;
  logic           bank, bank_nxt, drop_nxt;
  logic           wr_in, rd_in, pr_in;
  logic [PAW-1:0] wr_phys, rd_phys, pr_phys;
  logic [DW-1:0]  mem [2*NPIX];
  logic [DW-1:0]  rd_raw, pr_raw;
  sel_t           rd_sel, pr_sel;

  function automatic logic [PAW-1:0] phys(input logic b, input logic [AW-1:0] a,
                                          input logic ok);
    logic [PAW-1:0] base;
    base = b ? NPIX_P : '0;
    return ok ? base + PAW'({1'b0, a}) : base;
  endfunction

  assign wr_in   = {1'b0, wr_addr}   < NPIX_A;
  assign rd_in   = {1'b0, rd_addr}   < NPIX_A;
  assign pr_in   = {1'b0, proc_addr} < NPIX_A;
  assign wr_phys = phys(bank,  wr_addr,   wr_in);
  assign rd_phys = phys(~bank, rd_addr,   rd_in);
  assign pr_phys = phys(~bank, proc_addr, pr_in);

  // Plain RAM with one write and two registered reads; range handling sits
  // after the read registers so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in) mem[wr_phys] <= wr_data;
    rd_raw <= mem[rd_phys];
    if (proc_rd_en) pr_raw <= mem[pr_phys];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sel     <= SEL_ZERO;
      pr_sel     <= SEL_ZERO;
      proc_valid <= 1'b0;
      wr_oob     <= 1'b0;
    end else begin
      rd_sel     <= rd_in ? SEL_MEM : SEL_BLANK;
      proc_valid <= proc_rd_en;
      if (proc_rd_en) pr_sel <= pr_in ? SEL_MEM : SEL_BLANK;
      if (wr_en && !wr_in) wr_oob <= 1'b1;
    end
  end

  assign rd_data   = (rd_sel == SEL_MEM) ? rd_raw :
                     (rd_sel == SEL_BLANK) ? BLANK : '0;
  assign proc_data = (pr_sel == SEL_MEM) ? pr_raw :
                     (pr_sel == SEL_BLANK) ? BLANK : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_FILL;
      bank          <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      state         <= state_nxt;
      bank          <= bank_nxt;
      frame_dropped <= drop_nxt;
    end
  end

  // A frame end coinciding with a frame start swaps straight away.
  always_comb begin
    state_nxt = state;
    bank_nxt  = bank;
    drop_nxt  = 1'b0;
    case (state)
      ST_FILL: begin
        if (wr_frame_end && rd_frame_start) bank_nxt = ~bank;
        else if (wr_frame_end)              state_nxt = ST_READY;
      end
      ST_READY: begin
        if (rd_frame_start) begin
          bank_nxt  = ~bank;
          state_nxt = ST_FILL;
        end else if (wr_frame_end) begin
          drop_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  assign wr_bank     = bank;
  assign frame_ready = (state == ST_READY);

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Bench for frame_buffer_pp: per-bank array model checked every cycle, plus
// directed literal checks that follow the block's test plan.
module tb_frame_buffer_pp;
  localparam int AW = 15, DW = 12, IMG_W = 160, IMG_H = 120;
  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [DW-1:0] BLANK = 12'h000;

  logic          clk, reset;
  logic          wr_en, wr_frame_end, rd_frame_start, proc_rd_en;
  logic [AW-1:0] wr_addr, rd_addr, proc_addr;
  logic [DW-1:0] wr_data, rd_data, proc_data;
  logic          proc_valid, wr_bank, frame_ready, frame_dropped, wr_oob;

  int tests = 0, fails = 0;
  bit chk_en = 0;

  frame_buffer_pp #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_end(wr_frame_end), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_frame_start(rd_frame_start), .proc_rd_en(proc_rd_en), .proc_addr(proc_addr),
    .proc_data(proc_data), .proc_valid(proc_valid), .wr_bank(wr_bank),
    .frame_ready(frame_ready), .frame_dropped(frame_dropped), .wr_oob(wr_oob));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Model: two banks as plain arrays, a known-flag per word for never-written
  // storage, and the swap rules applied directly.
  logic [DW-1:0] m_mem [2][NPIX];
  bit            m_known [2][NPIX];
  logic          m_bank, m_pend, m_drop, m_oob, m_pv;
  logic [DW-1:0] m_rd, m_pd;
  bit            m_rd_k, m_pd_k;

  function automatic logic [DW-1:0] look_d(input int b, input int a);
    if (a >= NPIX) return BLANK;
    return m_mem[b][a];
  endfunction

  function automatic bit look_k(input int b, input int a);
    if (a >= NPIX) return 1'b1;
    return m_known[b][a];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_bank <= 0; m_pend <= 0; m_drop <= 0; m_oob <= 0; m_pv <= 0;
      m_rd <= '0; m_rd_k <= 1; m_pd <= '0; m_pd_k <= 1;
    end else begin
      int front, back, wa;
      front = m_bank ? 0 : 1;
      back  = m_bank ? 1 : 0;
      m_rd   <= look_d(front, int'(rd_addr));
      m_rd_k <= look_k(front, int'(rd_addr));
      m_pv   <= proc_rd_en;
      if (proc_rd_en) begin
        m_pd   <= look_d(front, int'(proc_addr));
        m_pd_k <= look_k(front, int'(proc_addr));
      end
      wa = int'(wr_addr);
      if (wr_en) begin
        if (wa < NPIX) begin
          m_mem[back][wa]   <= wr_data;
          m_known[back][wa] <= 1'b1;
        end else m_oob <= 1'b1;
      end
      m_drop <= wr_frame_end && m_pend && !rd_frame_start;
      if (rd_frame_start && (m_pend || wr_frame_end)) begin
        m_bank <= ~m_bank;
        m_pend <= 1'b0;
      end else if (wr_frame_end) m_pend <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      cmp("m_wr_bank", 32'(wr_bank), 32'(m_bank));
      cmp("m_frame_ready", 32'(frame_ready), 32'(m_pend));
      cmp("m_frame_dropped", 32'(frame_dropped), 32'(m_drop));
      cmp("m_wr_oob", 32'(wr_oob), 32'(m_oob));
      cmp("m_proc_valid", 32'(proc_valid), 32'(m_pv));
      if (m_rd_k) cmp("m_rd_data", 32'(rd_data), 32'(m_rd));
      if (m_pd_k) cmp("m_proc_data", 32'(proc_data), 32'(m_pd));
    end
  end

  task automatic pulse_end();
    @(negedge clk) wr_frame_end = 1;
    @(negedge clk) wr_frame_end = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) rd_frame_start = 1;
    @(negedge clk) rd_frame_start = 0;
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = AW'(a); wr_data = d;
    @(negedge clk) wr_en = 0;
  endtask

  initial begin
    reset = 1; wr_en = 0; wr_addr = '0; wr_data = '0; wr_frame_end = 0;
    rd_addr = '0; rd_frame_start = 0; proc_rd_en = 0; proc_addr = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk_en = 1;
    cmp("rst_wr_bank", 32'(wr_bank), 0);
    cmp("rst_frame_ready", 32'(frame_ready), 0);
    cmp("rst_wr_oob", 32'(wr_oob), 0);
    cmp("rst_proc_valid", 32'(proc_valid), 0);
    cmp("rst_rd_data", 32'(rd_data), 0);

    // Full frame into bank 0, then swap it to the front.
    for (int i = 0; i < NPIX; i++) write_word(i, DW'(i));
    pulse_end();
    cmp("ready_after_end", 32'(frame_ready), 1);
    pulse_start();
    cmp("bank_after_swap", 32'(wr_bank), 1);
    cmp("ready_after_swap", 32'(frame_ready), 0);
    rd_addr = AW'(5);
    @(negedge clk);
    cmp("rd5", 32'(rd_data), 32'h005);

    // Out-of-image reads, back-to-back processing reads, then hold.
    rd_addr = AW'(19200); proc_addr = AW'(32767); proc_rd_en = 1;
    @(negedge clk);
    cmp("rd_oob_blank", 32'(rd_data), 32'h000);
    cmp("proc_oob_blank", 32'(proc_data), 32'h000);
    cmp("proc_valid_1", 32'(proc_valid), 1);
    proc_addr = AW'(7);
    @(negedge clk) proc_rd_en = 0;
    cmp("proc7", 32'(proc_data), 32'h007);
    cmp("proc_valid_b2b", 32'(proc_valid), 1);
    @(negedge clk);
    cmp("proc_valid_drop", 32'(proc_valid), 0);
    cmp("proc_hold", 32'(proc_data), 32'h007);

    // Partial frame into bank 1, two frame ends -> drop pulse.
    for (int i = 0; i < 16; i++) write_word(i, DW'(12'h100 + i));
    pulse_end();
    cmp("ready_first_end", 32'(frame_ready), 1);
    cmp("no_drop_first", 32'(frame_dropped), 0);
    pulse_end();
    cmp("drop_second", 32'(frame_dropped), 1);
    cmp("ready_kept", 32'(frame_ready), 1);
    @(negedge clk);
    cmp("drop_one_cycle", 32'(frame_dropped), 0);
    pulse_start();
    cmp("bank_back0", 32'(wr_bank), 0);
    rd_addr = AW'(3);
    @(negedge clk);
    cmp("rd_bank1_3", 32'(rd_data), 32'h103);

    // Simultaneous frame end and frame start with nothing pending.
    @(negedge clk) begin wr_frame_end = 1; rd_frame_start = 1; end
    @(negedge clk) begin wr_frame_end = 0; rd_frame_start = 0; end
    cmp("simul_bank", 32'(wr_bank), 1);
    cmp("simul_ready", 32'(frame_ready), 0);
    cmp("simul_drop", 32'(frame_dropped), 0);
    rd_addr = AW'(5);
    @(negedge clk);
    cmp("simul_ready2", 32'(frame_ready), 0);
    cmp("simul_rd5", 32'(rd_data), 32'h005);

    // Illegal write address; every word of the front bank must be intact.
    write_word(19200, 12'hABC);
    cmp("oob_set", 32'(wr_oob), 1);
    for (int i = 0; i < NPIX; i++) begin
      rd_addr = AW'(i);
      @(negedge clk);
      cmp("scan_bank0", 32'(rd_data), 32'(i & 32'hFFF));
    end
    cmp("oob_sticky", 32'(wr_oob), 1);
    pulse_end();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      rd_addr = AW'(i);
      @(negedge clk);
      cmp("scan_bank1", 32'(rd_data), 32'(12'h100 + i));
    end

    // Asynchronous reset while a frame is pending.
    @(negedge clk) begin wr_frame_end = 1; rd_frame_start = 1; end
    @(negedge clk) begin wr_frame_end = 0; rd_frame_start = 0; end
    pulse_end();
    proc_rd_en = 1; proc_addr = AW'(9); rd_addr = AW'(5);
    @(negedge clk) proc_rd_en = 0;
    cmp("pre_rst_ready", 32'(frame_ready), 1);
    cmp("pre_rst_bank", 32'(wr_bank), 1);
    cmp("pre_rst_pvalid", 32'(proc_valid), 1);
    cmp("pre_rst_pdata", 32'(proc_data), 32'h009);
    cmp("pre_rst_rd", 32'(rd_data), 32'h005);
    #2 reset = 1;
    #1;
    cmp("arst_bank", 32'(wr_bank), 0);
    cmp("arst_ready", 32'(frame_ready), 0);
    cmp("arst_pvalid", 32'(proc_valid), 0);
    cmp("arst_rd", 32'(rd_data), 0);
    cmp("arst_oob", 32'(wr_oob), 0);
    cmp("arst_pdata", 32'(proc_data), 0);
    @(negedge clk);
    @(negedge clk) reset = 0;
    pulse_start();
    cmp("no_swap_after_rst", 32'(wr_bank), 0);
    cmp("no_ready_after_rst", 32'(frame_ready), 0);
    @(negedge clk);
    cmp("rd_front1_after_rst", 32'(rd_data), 32'h105);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
